sobel_stream: RTL and testbench
===============================

# sobel_stream

Parametrised streaming Sobel edge detector, next generation of the camera-to-HDMI edge path: accepts one RGB pixel per valid cycle from the camera capture block, converts to luma, builds a 3x3 window from two internal line buffers and emits a gradient-magnitude pixel per input pixel. Image width, height and channel width are parameters. The block has frame tracking, border blanking, saturation and an optional binary-threshold mode.

## Interface
- IMG_W, 640, pixels per line (>= 3)
- IMG_H, 480, lines per frame (>= 3)
- PIX_W, 8, bits per colour channel and per output channel
- sys_clk_i  in  1  single clock for all logic
- sys_rst_i  in  1  reset: synchronous, active-low
- pix_valid_i  in  1  input pixel valid
- pix_sof_i  in  1  first pixel of frame; qualified by pix_valid_i
- cam_red_i / cam_green_i / cam_blue_i  in  PIX_W each  input pixel
- thresh_i  in  PIX_W  threshold; used only with SOBEL_THRESH_EN
- sobel_red_o / sobel_green_o / sobel_blue_o  out  PIX_W each  result; all three channels equal
- sobel_valid_o  out  1  result valid
- sobel_sof_o  out  1  result corresponds to first input pixel of frame
- sobel_done_o  out  1  one-cycle pulse with the result of the last pixel of a frame

## Operation
- Luma: gray = (R + 2G + B) >> 2, intermediate PIX_W+2 bits, result PIX_W bits.
- Counters x (0..IMG_W-1) and y (0..IMG_H-1) advance on each valid pixel. x wraps to 0 and increments y. After (IMG_W-1, IMG_H-1), both wrap to 0, so sof is optional.
- pix_sof_i with valid forces that pixel to (0,0), including mid-frame. Stale line-buffer data is masked by the border rule.
- Window: columns shift on each valid pixel. Rows are line buffer 1 (y-2), line buffer 0 (y-1) and the current pixel. Buffers are read and written at address x, read-before-write.
- Output k corresponds to the window centred at (x-1, y-1) of input k. The output image is shifted one line and one column.
- Border: output is 0 when x < 2 or y < 2.
- Gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20).
- Gy = (p20 + 2p21 + p22) - (p00 + 2p01 + p02).
- Gx and Gy are signed, PIX_W+3 bits.
- mag = |Gx| + |Gy|, PIX_W+3 bits unsigned, saturated to 2^PIX_W - 1.
- The output count always equals the input count. There is no back-pressure.
- sobel_done_o is asserted with the output of the input pixel at (IMG_W-1, IMG_H-1).

## Timing
- Four-stage pipeline, fixed latency 4: input valid at cycle n gives sobel_valid_o at n+4.
  - S1: luma and counters.
  - S2: line-buffer read and window shift.
  - S3: Gx and Gy.
  - S4: magnitude, saturation and threshold into output registers.
- Valid, sof and done travel in the pipeline with their data. Bubbles pass through unchanged, and there is no stall.
- Reset (sys_rst_i low at a clock edge):
  - All outputs become 0 on the next edge.
  - Counters go to 0 and pipeline valids are cleared.
  - The captured threshold goes to 0.
  - Line-buffer RAM is not reset.
- Reset mid-frame drops in-flight pixels. No sobel_valid_o occurs until 4 cycles after the next accepted input.
- Back-to-back frames (sof on the cycle after the last pixel) are supported with no gap.

## Configuration
- SOBEL_THRESH_EN defined:
  - thresh_i is captured on the cycle that pix_sof_i is accepted and held for the whole frame.
  - Output is all ones when mag > threshold, else 0. Border pixels stay 0.
- SOBEL_THRESH_EN undefined:
  - thresh_i is ignored and the saturated magnitude is output.
  - No threshold register is synthesised.

## Structure
- Package sobel_pkg holds:
  - Luma weights and shift.
  - Counter width function ($clog2 based).
  - abs and saturate functions.
  - The signed gradient width constant PIX_W+3, as a function of PIX_W.
- Sub-module sobel_line_buf: simple dual-port RAM, IMG_W deep, PIX_W wide, 1-cycle read, read-before-write at the same address. Two instances.

## Test plan
- Uniform grey frame (R=G=B=100), IMG_W=8, IMG_H=6 -> 48 valid outputs, all 0, latency 4 cycles, done on the 48th output only.
- Vertical step, columns 0-3 = 0 and 4-7 = 200, PIX_W=8 -> outputs at input x=4 and x=5 for y>=2 are 255 (Gx=800 saturated), all other outputs 0.
- Small step, left 0 and right 10 -> the same two positions give 40, elsewhere 0. Horizontal step of 10 at row 3 -> 40 at input y=3 and y=4 for x>=2.
- SOBEL_THRESH_EN defined, step 10:
  - thresh_i=30 -> 255 at the edge positions.
  - thresh_i=50 -> all 0.
  - thresh_i changed mid-frame -> no effect until the next sof.
- pix_sof_i reasserted after 20 pixels -> counters restart, the first two lines of the new frame output 0, done only after a further 48 pixels.
- One-cycle reset with 3 pixels in flight -> all outputs 0 the next cycle, those pixels produce no valid output, and the following sof frame matches the uniform-frame result.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the streaming Sobel edge detector.
package sobel_pkg;

  localparam int LUMA_WR = 1;
  localparam int LUMA_WG = 2;
  localparam int LUMA_WB = 1;
  localparam int LUMA_SH = 2;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Worst-case |Gx| is 4*(2^PIX_W-1), so three extra bits cover the signed range
  function automatic int grad_w(input int pw);
    return pw + 3;
  endfunction

  function automatic logic [31:0] abs32(input logic signed [31:0] v);
    return (v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [31:0] sat32(input logic [31:0] v, input int pw);
    logic [31:0] mx;
    mx = (32'd1 << pw) - 32'd1;
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Simple dual-port line RAM: 1-cycle registered read, read-before-write.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic                     gclk,
  input  logic                     we,
  input  logic [cnt_w(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [cnt_w(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge gclk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel on luma, fixed 4-cycle latency, no back-pressure.
// Define SOBEL_THRESH_EN for binary output against a per-frame threshold.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic             pix_valid_i,
  input  logic             pix_sof_i,
  input  logic [PIX_W-1:0] cam_red_i,
  input  logic [PIX_W-1:0] cam_green_i,
  input  logic [PIX_W-1:0] cam_blue_i,
  input  logic [PIX_W-1:0] thresh_i,
  output logic [PIX_W-1:0] sobel_red_o,
  output logic [PIX_W-1:0] sobel_green_o,
  output logic [PIX_W-1:0] sobel_blue_o,
  output logic             sobel_valid_o,
  output logic             sobel_sof_o,
  output logic             sobel_done_o
);

  localparam int STAGES = 4;
  localparam int XW     = cnt_w(IMG_W);
  localparam int YW     = cnt_w(IMG_H);
  localparam int GW     = grad_w(PIX_W);
  localparam int SW     = PIX_W + 2;

  logic [STAGES:1] vld_pipe, sof_pipe, done_pipe;
  logic [3:1]      bord_pipe;

  // S1: luma and position
  logic [SW-1:0]    luma_sum;
  logic [PIX_W-1:0] gray;
  logic [XW-1:0]    cnt_x, cur_x, nxt_x;
  logic [YW-1:0]    cnt_y, cur_y, nxt_y;
  logic             last_px;

  always_comb begin
    luma_sum = SW'(cam_red_i) * SW'(LUMA_WR) + SW'(cam_green_i) * SW'(LUMA_WG)
             + SW'(cam_blue_i) * SW'(LUMA_WB);
    gray     = PIX_W'(luma_sum >> LUMA_SH);
    cur_x    = pix_sof_i ? '0 : cnt_x;
    cur_y    = pix_sof_i ? '0 : cnt_y;
    last_px  = (cur_x == XW'(IMG_W - 1)) && (cur_y == YW'(IMG_H - 1));
    nxt_x    = cur_x + 1'b1;
    nxt_y    = cur_y;
    if (cur_x == XW'(IMG_W - 1)) begin
      nxt_x = '0;
      nxt_y = (cur_y == YW'(IMG_H - 1)) ? '0 : cur_y + 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      cnt_x     <= '0;
      cnt_y     <= '0;
      vld_pipe  <= '0;
      sof_pipe  <= '0;
      done_pipe <= '0;
    end else begin
      if (pix_valid_i) begin
        cnt_x <= nxt_x;
        cnt_y <= nxt_y;
      end
      vld_pipe  <= {vld_pipe[STAGES-1:1], pix_valid_i};
      sof_pipe  <= {sof_pipe[STAGES-1:1], pix_valid_i & pix_sof_i};
      done_pipe <= {done_pipe[STAGES-1:1], pix_valid_i & last_px};
    end
  end

  logic [PIX_W-1:0] s1_gray, s2_gray;
  logic [XW-1:0]    s1_x, s2_x;

  // S2: line buffers. lb1 is fed from lb0's read-before-write data one cycle later,
  // so it always holds the line two rows up.
  logic [PIX_W-1:0] rd0, rd1;

  sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .gclk  (sys_clk_i),
    .we    (vld_pipe[1]),
    .waddr (s1_x),
    .wdata (s1_gray),
    .raddr (s1_x),
    .rdata (rd0)
  );

  sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .gclk  (sys_clk_i),
    .we    (vld_pipe[2]),
    .waddr (s2_x),
    .wdata (rd0),
    .raddr (s1_x),
    .rdata (rd1)
  );

  // Window columns indexed by row: [0]=y-2, [1]=y-1, [2]=y; col2 is the newest column
  logic [2:0][PIX_W-1:0]  col0, col1, col2;
  logic signed [GW-1:0]   gx, gy, s3_gx, s3_gy;

  assign col2 = {s2_gray, rd0, rd1};

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return GW'(p);
  endfunction

  always_comb begin
    gx = (ext(col2[0]) + ext(col2[1]) + ext(col2[1]) + ext(col2[2]))
       - (ext(col0[0]) + ext(col0[1]) + ext(col0[1]) + ext(col0[2]));
    gy = (ext(col0[2]) + ext(col1[2]) + ext(col1[2]) + ext(col2[2]))
       - (ext(col0[0]) + ext(col1[0]) + ext(col1[0]) + ext(col2[0]));
  end

  always_ff @(posedge sys_clk_i) begin
    s1_gray   <= gray;
    s1_x      <= cur_x;
    bord_pipe <= {bord_pipe[2:1], (cur_x < XW'(2)) || (cur_y < YW'(2))};
    s2_gray   <= s1_gray;
    s2_x      <= s1_x;
    if (vld_pipe[2]) begin
      col0 <= col1;
      col1 <= col2;
    end
    s3_gx <= gx;
    s3_gy <= gy;
  end

  // S4: magnitude and output formatting
  logic [31:0]      mag;
  logic [PIX_W-1:0] s4_pix, pix_q;

`ifdef SOBEL_THRESH_EN
  logic [PIX_W-1:0] thr_q, s1_thr, s2_thr, s3_thr;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i)                    thr_q <= '0;
    else if (pix_valid_i && pix_sof_i) thr_q <= thresh_i;
  end

  // The threshold rides with its pixels so back-to-back frames never mix values
  always_ff @(posedge sys_clk_i) begin
    s1_thr <= (pix_valid_i && pix_sof_i) ? thresh_i : thr_q;
    s2_thr <= s1_thr;
    s3_thr <= s2_thr;
  end

  always_comb begin
    mag    = abs32(32'(s3_gx)) + abs32(32'(s3_gy));
    s4_pix = (mag > 32'(s3_thr)) ? '1 : '0;
    if (bord_pipe[3]) s4_pix = '0;
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh_i;

  always_comb begin
    mag    = abs32(32'(s3_gx)) + abs32(32'(s3_gy));
    s4_pix = PIX_W'(sat32(mag, PIX_W));
    if (bord_pipe[3]) s4_pix = '0;
  end
`endif

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) pix_q <= '0;
    else            pix_q <= s4_pix;
  end

  assign sobel_red_o   = pix_q;
  assign sobel_green_o = pix_q;
  assign sobel_blue_o  = pix_q;
  assign sobel_valid_o = vld_pipe[STAGES];
  assign sobel_sof_o   = sof_pipe[STAGES];
  assign sobel_done_o  = done_pipe[STAGES];

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream: image-array reference model, randomized frames.
module tb_sobel_stream;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 8;

  logic          clk;
  logic          sys_rst_i;
  logic          pix_valid_i, pix_sof_i;
  logic [PW-1:0] cam_red_i, cam_green_i, cam_blue_i, thresh_i;
  logic [PW-1:0] sobel_red_o, sobel_green_o, sobel_blue_o;
  logic          sobel_valid_o, sobel_sof_o, sobel_done_o;

  sobel_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .sys_clk_i     (clk),
    .sys_rst_i     (sys_rst_i),
    .pix_valid_i   (pix_valid_i),
    .pix_sof_i     (pix_sof_i),
    .cam_red_i     (cam_red_i),
    .cam_green_i   (cam_green_i),
    .cam_blue_i    (cam_blue_i),
    .thresh_i      (thresh_i),
    .sobel_red_o   (sobel_red_o),
    .sobel_green_o (sobel_green_o),
    .sobel_blue_o  (sobel_blue_o),
    .sobel_valid_o (sobel_valid_o),
    .sobel_sof_o   (sobel_sof_o),
    .sobel_done_o  (sobel_done_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int pix;
    bit sof;
    bit done;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: position, per-frame threshold and the gray image
  int m_x = 0, m_y = 0, m_thr = 0;
  int img [H][W];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void model_push(input int r, input int g, input int b,
                                     input bit sof, input int thr);
    exp_t e;
    int gx, gy, mag, wgt;
    if (sof) begin
      m_x = 0; m_y = 0; m_thr = thr;
    end
    img[m_y][m_x] = (r + 2 * g + b) / 4;
    e.pix = 0;
    if (m_x >= 2 && m_y >= 2) begin
      gx = 0; gy = 0;
      for (int k = 0; k < 3; k++) begin
        wgt = (k == 1) ? 2 : 1;
        gx += wgt * (img[m_y-2+k][m_x] - img[m_y-2+k][m_x-2]);
        gy += wgt * (img[m_y][m_x-2+k] - img[m_y-2][m_x-2+k]);
      end
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
      e.pix = (mag > m_thr) ? 255 : 0;
`else
      e.pix = (mag > 255) ? 255 : mag;
`endif
    end
    e.sof  = sof;
    e.done = (m_x == W - 1) && (m_y == H - 1);
    e.cyc  = cyc + 4;
    q.push_back(e);
    if (m_x == W - 1) begin
      m_x = 0;
      m_y = (m_y == H - 1) ? 0 : m_y + 1;
    end else begin
      m_x++;
    end
  endfunction

  task automatic send(input int r, input int g, input int b, input bit sof, input int thr);
    @(posedge clk); #1;
    pix_valid_i = 1;
    pix_sof_i   = sof;
    cam_red_i   = PW'(r);
    cam_green_i = PW'(g);
    cam_blue_i  = PW'(b);
    thresh_i    = PW'(thr);
    model_push(r, g, b, sof, thr);
  endtask

  // Idle cycles toggle sof/data randomly to show they are ignored without valid
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pix_valid_i = 0;
      pix_sof_i   = 1'($urandom_range(0, 1));
      cam_red_i   = PW'($urandom_range(0, 255));
      cam_green_i = PW'($urandom_range(0, 255));
      cam_blue_i  = PW'($urandom_range(0, 255));
      thresh_i    = PW'($urandom_range(0, 255));
    end
  endtask

  // kind: 0 uniform 100, 1 vertical step 0/200, 2 vertical step 0/10,
  //       3 horizontal step 0/10 at row 3, 4 random RGB
  task automatic run_frame(input int kind, input int thr, input bit first_sof,
                           input int bubble_pct, input int npix);
    for (int i = 0; i < npix; i++) begin
      int px, py, r, g, b;
      bit sof;
      sof = (i == 0) && first_sof;
      px  = sof ? 0 : m_x;
      py  = sof ? 0 : m_y;
      case (kind)
        0: begin r = 100; g = 100; b = 100; end
        1: begin r = (px >= 4) ? 200 : 0; g = r; b = r; end
        2: begin r = (px >= 4) ? 10 : 0;  g = r; b = r; end
        3: begin r = (py >= 3) ? 10 : 0;  g = r; b = r; end
        default: begin
          r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
        end
      endcase
      if (bubble_pct > 0 && $urandom_range(0, 99) < bubble_pct)
        idle($urandom_range(1, 2));
      send(r, g, b, sof, sof ? thr : $urandom_range(0, 255));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, int'(sobel_valid_o), 0);
    check({tag, "_sof"},   int'(sobel_sof_o),   0);
    check({tag, "_done"},  int'(sobel_done_o),  0);
    check({tag, "_red"},   int'(sobel_red_o),   0);
    check({tag, "_green"}, int'(sobel_green_o), 0);
    check({tag, "_blue"},  int'(sobel_blue_o),  0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    pix_valid_i = 0;
    sys_rst_i   = 0;
    @(posedge clk); #1;
    check_outputs_zero("reset");
    q.delete();
    m_x = 0; m_y = 0; m_thr = 0;
    sys_rst_i = 1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    if (sobel_valid_o) begin
      if (q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency_cycle", cyc, e.cyc);
        check("pix_red",   int'(sobel_red_o),   e.pix);
        check("pix_green", int'(sobel_green_o), e.pix);
        check("pix_blue",  int'(sobel_blue_o),  e.pix);
        check("sof",  int'(sobel_sof_o),  int'(e.sof));
        check("done", int'(sobel_done_o), int'(e.done));
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      check("missing_valid", cyc, q[0].cyc);
      void'(q.pop_front());
    end
  end

  initial begin
    sys_rst_i   = 0;
    pix_valid_i = 0;
    pix_sof_i   = 0;
    cam_red_i   = '0;
    cam_green_i = '0;
    cam_blue_i  = '0;
    thresh_i    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("init");
    sys_rst_i = 1;
    idle(2);

    run_frame(0, 0,  1, 0, W * H);
    run_frame(1, 0,  1, 0, W * H);
    run_frame(2, 30, 1, 0, W * H);
    run_frame(3, 30, 1, 0, W * H);
    run_frame(2, 50, 1, 0, W * H);
    idle(3);
    // Random frames with bubbles; some rely on the counter wrap instead of sof
    for (int f = 0; f < 6; f++)
      run_frame(4, $urandom_range(0, 255), (f == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 25, W * H);

    // sof re-asserted mid-frame restarts counting
    run_frame(4, 40, 1, 0, 20);
    run_frame(2, 5,  1, 10, W * H);

    // Reset with pixels in flight, then a clean uniform frame
    run_frame(4, 0, 1, 0, 3);
    do_reset();
    idle(2);
    run_frame(0, 0, 1, 0, W * H);
    idle(1);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
